reg_file_2r1w: RTL and testbench

- Parametrised register file: DEPTH x DW storage, one write port, two independent asynchronous read ports.
- Built-in clear sequencer zeroes the array one entry per cycle on request, without asserting rst.
- Next-generation general-purpose register bank for the CPU datapath: operand A/B reads plus writeback in the same cycle.

---
 rtl/reg_file_pkg.sv | 6 +
 rtl/reg_file_clr_ctrl.sv | 42 ++++
 rtl/reg_file_2r1w.sv | 54 +++++
 tb/tb_reg_file_2r1w.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// reg_file_pkg: clear-FSM state encoding and default register-file sizes
package reg_file_pkg;
   typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} clr_state_e;
   localparam int DEF_DW = 4;
   localparam int DEF_AW = 4;
endpackage

// File: rtl/reg_file_clr_ctrl.sv
// reg_file_clr_ctrl: IDLE/SWEEP sequencer that zeroes one entry per cycle
module reg_file_clr_ctrl
   import reg_file_pkg::*;
#(
   parameter int AW    = DEF_AW,
   parameter int DEPTH = 1 << AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_req,
   output logic          clr_busy,
   output logic          clr_done,
   output logic          clr_we,
   output logic [AW-1:0] clr_addr
);
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
   clr_state_e    r_state, w_next;
   logic [AW-1:0] r_cnt;
   logic          r_done;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_cnt   <= (r_state == SWEEP) ? r_cnt + AW'(1) : '0;
         r_done  <= (r_state == SWEEP) && (r_cnt == LAST);
      end
   end
   // clr_req is only looked at in IDLE, so a request mid-sweep is dropped
   always_comb begin
      w_next = (r_state == IDLE) ? (clr_req ? SWEEP : IDLE)
                                 : ((r_cnt == LAST) ? IDLE : SWEEP);
   end
   always_comb begin
      clr_busy = (r_state == SWEEP);
      clr_we   = (r_state == SWEEP);
      clr_addr = r_cnt;
      clr_done = r_done;
   end
endmodule

// File: rtl/reg_file_2r1w.sv
// reg_file_2r1w: DEPTH x DW register file, 1 write / 2 async read ports, clear sweep.
// Optional REG_FILE_WR_BYPASS_EN forwards same-cycle write data to matching read ports.
module reg_file_2r1w
   import reg_file_pkg::*;
#(
   parameter int DW    = DEF_DW,
   parameter int AW    = DEF_AW,
   parameter int DEPTH = 1 << AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr0,
   output logic [DW-1:0] rdata0,
   input  logic [AW-1:0] raddr1,
   output logic [DW-1:0] rdata1,
   input  logic          clr_req,
   output logic          clr_busy,
   output logic          clr_done
);
   logic [DW-1:0] r_mem [DEPTH];
   logic          w_clr_we;
   logic [AW-1:0] w_clr_addr;
   reg_file_clr_ctrl #(.AW(AW), .DEPTH(DEPTH)) u_clr (
      .clk      (clk),
      .rst      (rst),
      .clr_req  (clr_req),
      .clr_busy (clr_busy),
      .clr_done (clr_done),
      .clr_we   (w_clr_we),
      .clr_addr (w_clr_addr)
   );
   // the sweep owns the write port while busy; external writes are dropped
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (w_clr_we) begin
         r_mem[w_clr_addr] <= '0;
      end else if (we) begin
         r_mem[waddr] <= wdata;
      end
   end
`ifdef REG_FILE_WR_BYPASS_EN
   logic w_byp_ok;
   assign w_byp_ok = we && !clr_busy;
   assign rdata0   = (w_byp_ok && raddr0 == waddr) ? wdata : r_mem[raddr0];
   assign rdata1   = (w_byp_ok && raddr1 == waddr) ? wdata : r_mem[raddr1];
`else
   assign rdata0 = r_mem[raddr0];
   assign rdata1 = r_mem[raddr1];
`endif
endmodule

// File: tb/tb_reg_file_2r1w.sv
// tb_reg_file_2r1w: directed stimulus, per-cycle model compare plus literal checks
module tb_reg_file_2r1w;
`ifdef REG_FILE_WR_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   logic clk = 1'b0, rst = 1'b1, we = 1'b0, clr_req = 1'b0;
   logic [3:0] waddr = '0, wdata = '0, raddr0 = '0, raddr1 = '0;
   logic [3:0] rdata0, rdata1;
   logic clr_busy, clr_done;
   int n_chk = 0, n_fail = 0;
   logic [3:0] m_mem [16];
   int m_left = 0;
   bit m_done = 1'b0, chk_en = 1'b0;
   int n_busy, n_done;

   reg_file_2r1w dut (
      .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
      .raddr0(raddr0), .rdata0(rdata0), .raddr1(raddr1), .rdata1(rdata1),
      .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // model: m_left counts the sweep cycles still to run
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) m_mem[i] = '0;
         m_left = 0;
         m_done = 1'b0;
      end else begin
         m_done = (m_left == 1);
         if (m_left > 0) begin
            m_mem[16 - m_left] = '0;
            m_left--;
         end else begin
            if (we) m_mem[waddr] = wdata;
            if (clr_req) m_left = 16;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_rdata0", rdata0, (BYP && we && m_left == 0 && raddr0 == waddr) ? wdata : m_mem[raddr0]);
         chk("m_rdata1", rdata1, (BYP && we && m_left == 0 && raddr1 == waddr) ? wdata : m_mem[raddr1]);
         chk("m_busy", clr_busy, m_left > 0);
         chk("m_done", clr_done, m_done);
      end
   end

   task automatic fill(input logic [3:0] v);
      for (int i = 0; i < 16; i++) begin
         we = 1'b1; waddr = 4'(i); wdata = v;
         tick();
      end
      we = 1'b0;
   endtask

   task automatic read_all_zero(input string nm);
      for (int i = 0; i < 16; i++) begin
         raddr0 = 4'(i); raddr1 = 4'(15 - i);
         #2;
         chk(nm, {rdata0, rdata1}, 8'h00);
         tick();
      end
   endtask

   // counts busy cycles and done pulses over a fixed window starting at sweep cycle 0
   task automatic sweep_window(input bit conflict, input bit mid_read);
      n_busy = 0; n_done = 0;
      for (int c = 0; c < 40; c++) begin
         if (conflict && c == 3) begin
            we = 1'b1; waddr = 4'd14; wdata = 4'h3; clr_req = 1'b1;
         end
         if (conflict && c == 4) begin
            we = 1'b0; clr_req = 1'b0;
         end
         if (mid_read && c == 5) begin
            raddr0 = 4'd2; raddr1 = 4'd10;
            #1;
            chk("mid_rd0", rdata0, 4'h0);
            chk("mid_rd1", rdata1, 4'hF);
         end
         #1;
         n_busy += int'(clr_busy);
         n_done += int'(clr_done);
         tick();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      tick();
      rst = 1'b0;
      chk_en = 1'b1;
      chk("rst_busy", clr_busy, 1'b0);
      chk("rst_done", clr_done, 1'b0);
      read_all_zero("rst_rd");
      // dual read
      we = 1'b1; waddr = 4'd3; wdata = 4'h5;
      tick();
      waddr = 4'd12; wdata = 4'hA;
      tick();
      we = 1'b0; raddr0 = 4'd3; raddr1 = 4'd12;
      #2;
      chk("dual_rd0", rdata0, 4'h5);
      chk("dual_rd1", rdata1, 4'hA);
      raddr0 = 4'd12;
      #1;
      chk("same_rd", {rdata0, rdata1}, 8'hAA);
      tick();
      // same-cycle write/read
      we = 1'b1; waddr = 4'd7; wdata = 4'h9; raddr0 = 4'd7;
      #2;
      chk("wr_rd_same", rdata0, BYP ? 4'h9 : 4'h0);
      tick();
      we = 1'b0;
      #2;
      chk("wr_rd_next", rdata0, 4'h9);
      tick();
      // clear sweep
      fill(4'hF);
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      sweep_window(1'b0, 1'b1);
      chk("sweep_busy_len", n_busy, 16);
      chk("sweep_done_cnt", n_done, 1);
      read_all_zero("sweep_rd");
      // sweep with write and re-request mid-sweep
      fill(4'h7);
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      sweep_window(1'b1, 1'b0);
      chk("conf_busy_len", n_busy, 16);
      chk("conf_done_cnt", n_done, 1);
      raddr0 = 4'd14;
      #2;
      chk("conf_rd14", rdata0, 4'h0);
      tick();
      // reset mid-sweep
      fill(4'hF);
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      for (int c = 0; c < 8; c++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #2;
      chk("rst_mid_busy", clr_busy, 1'b0);
      n_done = 0;
      for (int c = 0; c < 20; c++) begin
         n_done += int'(clr_done);
         tick();
      end
      chk("rst_mid_done", n_done, 0);
      read_all_zero("rst_mid_rd");
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
